// File: rtl/rf_pkg.sv
// Shared register-file types for the writeback path: address/data widths and
// the queued writeback entry.
package rf_pkg;
  localparam int RF_NREGS = 64;
  localparam int RF_AW    = $clog2(RF_NREGS);
  localparam int RF_DW    = 32;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Priority address match over an age-ordered candidate list (index 0 oldest);
// returns the youngest valid entry whose rd equals addr, or zero on a miss.
module wb_fwd_match
  import rf_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [RF_AW-1:0]        addr,
  input  wb_entry_t [N-1:0]       cand,
  input  logic [N-1:0]            cand_vld,
  output logic                    hit,
  output logic [RF_DW-1:0]        data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!hit && cand_vld[i] && (cand[i].rd == addr)) begin
        hit  = 1'b1;
        data = cand[i].data;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the RF write port: up to two retiring
// results in per cycle, one RF write out per cycle, with bypass of pending values.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          MEM_VALID,
  input  logic [AW-1:0] MEM_RD,
  input  logic [DW-1:0] MEM_DATA,
  input  logic          ALU_VALID,
  input  logic [AW-1:0] ALU_RD,
  input  logic [DW-1:0] ALU_DATA,
  output logic          STALL,
  output logic          OVF,
  output logic          WRT,
  output logic [AW-1:0] Rd,
  output logic [DW-1:0] DataIn,
  input  logic [AW-1:0] Rs,
  input  logic [AW-1:0] Rt,
  output logic          RS_HIT,
  output logic          RT_HIT,
  output logic [DW-1:0] RS_FWD,
  output logic [DW-1:0] RT_FWD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail, tail_alu;
  logic [CW-1:0] count, count_pop, free;
  logic          pop, push_mem, push_alu, drop;
  wb_entry_t     entries [DEPTH];

  // Occupancy is judged after this edge's pop so a full queue still accepts
  // a result in the same cycle it drains one.
  assign pop       = (count != '0);
  assign count_pop = count - CW'(pop);
  assign free      = CW'(DEPTH) - count_pop;
  assign push_mem  = MEM_VALID && (free != '0);
  assign push_alu  = ALU_VALID && (free > (push_mem ? CW'(1) : CW'(0)));
  assign drop      = (MEM_VALID && !push_mem) || (ALU_VALID && !push_alu);
  assign STALL     = (free < CW'(2));
  assign tail_alu  = tail + PW'(push_mem);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      WRT    <= 1'b0;
      Rd     <= '0;
      DataIn <= '0;
      OVF    <= 1'b0;
    end else begin
      count <= count_pop + CW'(push_mem) + CW'(push_alu);
      tail  <= tail + PW'(push_mem) + PW'(push_alu);
      WRT   <= pop;
      if (pop) begin
        head   <= head + PW'(1);
        Rd     <= entries[head].rd;
        DataIn <= entries[head].data;
      end
      if (drop) OVF <= 1'b1;
    end
  end

  // Entry payload carries no reset; validity is owned by head/count.
  always_ff @(posedge CLK) begin
    if (push_mem) entries[tail]     <= '{rd: MEM_RD, data: MEM_DATA};
    if (push_alu) entries[tail_alu] <= '{rd: ALU_RD, data: ALU_DATA};
  end

  // Age-ordered bypass view: the output register is the oldest candidate,
  // followed by queue entries from head towards tail.
  wb_entry_t [DEPTH:0] cand;
  logic      [DEPTH:0] cand_vld;

  always_comb begin
    cand[0]     = '{rd: Rd, data: DataIn};
    cand_vld[0] = WRT;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i+1]     = entries[head + PW'(i)];
      cand_vld[i+1] = (CW'(i) < count);
    end
  end

  wb_fwd_match #(.N(DEPTH + 1)) u_rs_match (
    .addr     (Rs),
    .cand     (cand),
    .cand_vld (cand_vld),
    .hit      (RS_HIT),
    .data     (RS_FWD)
  );

  wb_fwd_match #(.N(DEPTH + 1)) u_rt_match (
    .addr     (Rt),
    .cand     (cand),
    .cand_vld (cand_vld),
    .hit      (RT_HIT),
    .data     (RT_FWD)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: a queue-based reference model predicts
// RF writes, stall/overflow and bypass results under directed and random traffic.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          MEM_VALID, ALU_VALID;
  logic [AW-1:0] MEM_RD, ALU_RD, Rs, Rt, Rd;
  logic [DW-1:0] MEM_DATA, ALU_DATA, DataIn, RS_FWD, RT_FWD;
  logic          STALL, OVF, WRT, RS_HIT, RT_HIT;

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_VALID(MEM_VALID), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
    .STALL(STALL), .OVF(OVF), .WRT(WRT), .Rd(Rd), .DataIn(DataIn),
    .Rs(Rs), .Rt(Rt), .RS_HIT(RS_HIT), .RT_HIT(RT_HIT),
    .RS_FWD(RS_FWD), .RT_FWD(RT_FWD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  ent_t          exp_wr[$];
  logic          m_wrt, m_ovf;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    exp_wr.delete();
    m_wrt  = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_ovf  = 1'b0;
  endfunction

  function automatic logic model_stall();
    int after;
    after = mq.size() - ((mq.size() > 0) ? 1 : 0);
    return (DEPTH - after) < 2;
  endfunction

  function automatic void model_fwd(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (m_wrt && m_rd == a) begin
      h = 1'b1;
      d = m_data;
    end
    foreach (mq[i]) begin
      if (mq[i].rd == a) begin
        h = 1'b1;
        d = mq[i].data;
      end
    end
  endfunction

  // One rising edge of the reference: drain the oldest, then accept in age order.
  function automatic void model_edge();
    int   room;
    ent_t e;
    if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_wrt  = 1'b1;
      m_rd   = e.rd;
      m_data = e.data;
    end else begin
      m_wrt = 1'b0;
    end
    room = DEPTH - mq.size();
    if (MEM_VALID) begin
      if (room > 0) begin
        e.rd = MEM_RD; e.data = MEM_DATA;
        mq.push_back(e); exp_wr.push_back(e); room--;
      end else m_ovf = 1'b1;
    end
    if (ALU_VALID) begin
      if (room > 0) begin
        e.rd = ALU_RD; e.data = ALU_DATA;
        mq.push_back(e); exp_wr.push_back(e); room--;
      end else m_ovf = 1'b1;
    end
  endfunction

  task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
    MEM_VALID = mv; MEM_RD = mrd; MEM_DATA = md;
    ALU_VALID = av; ALU_RD = ard; ALU_DATA = ad;
  endtask

  task automatic cycle();
    logic          h;
    logic [DW-1:0] d;
    @(negedge CLK);
    check("stall", STALL, model_stall());
    check("ovf", OVF, m_ovf);
    check("wrt", WRT, m_wrt);
    check("rd", Rd, m_rd);
    check("data_in", DataIn, m_data);
    model_fwd(Rs, h, d);
    check("rs_hit", RS_HIT, h);
    check("rs_fwd", RS_FWD, d);
    model_fwd(Rt, h, d);
    check("rt_hit", RT_HIT, h);
    check("rt_fwd", RT_FWD, d);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Write monitor: every RF write must match the oldest unobserved accepted result.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && WRT === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h, expected no write", Rd, DataIn);
        end else begin
          ent_t e;
          e = exp_wr.pop_front();
          check("wr_rd", Rd, e.rd);
          check("wr_data", DataIn, e.data);
        end
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    Rs = '0;
    Rt = '0;
    model_reset();
    #22 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_wrt", WRT, 0);
    check("rst_rd", Rd, 0);
    check("rst_data", DataIn, 0);
    check("rst_ovf", OVF, 0);
    check("rst_stall", STALL, 0);

    // single MEM result: one write, next cycle idle
    drive(1, 5, 77, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("lat_wrt", WRT, 1);
    check("lat_rd", Rd, 5);
    check("lat_data", DataIn, 77);
    cycle();
    check("lat_idle", WRT, 0);

    // same rd from both stages: MEM older, ALU youngest for bypass
    drive(1, 2, 27, 1, 2, 99);
    Rs = 2; Rt = 3;
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("dup_wr1_rd", Rd, 2);
    check("dup_wr1_data", DataIn, 27);
    check("dup_rs_hit", RS_HIT, 1);
    check("dup_rs_fwd", RS_FWD, 99);
    cycle();
    check("dup_wr2_data", DataIn, 99);
    cycle();
    check("dup_idle", WRT, 0);

    // empty queue, no write: misses, held outputs
    Rs = 10; Rt = 11;
    #1;
    check("miss_rs_hit", RS_HIT, 0);
    check("miss_rt_hit", RT_HIT, 0);
    check("miss_rs_fwd", RS_FWD, 0);
    check("miss_rt_fwd", RT_FWD, 0);
    check("hold_rd", Rd, 2);
    check("hold_data", DataIn, 99);

    // back-to-back dual results until the queue overflows
    for (int k = 0; k < 3; k++) begin
      drive(1, AW'(8 + 2 * k), DW'(100 + 2 * k), 1, AW'(9 + 2 * k), DW'(101 + 2 * k));
      cycle();
    end
    check("full_stall", STALL, 1);
    check("full_ovf_clear", OVF, 0);
    drive(1, 20, 200, 1, 21, 201);
    cycle();
    check("ovf_set", OVF, 1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) cycle();

    // asynchronous reset with three entries pending and a write in flight
    drive(1, 30, 300, 1, 31, 301);
    cycle();
    drive(1, 32, 302, 1, 33, 303);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    Rs = 33;
    #2 RST_N = 1'b0;
    #1;
    check("arst_wrt", WRT, 0);
    check("arst_ovf", OVF, 0);
    check("arst_stall", STALL, 0);
    check("arst_rs_hit", RS_HIT, 0);
    check("arst_rd", Rd, 0);
    check("arst_data", DataIn, 0);
    model_reset();
    @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (5) cycle();

    // register 0 is ordinary
    drive(1, 0, 123, 0, 0, 0);
    Rs = 0; Rt = 0;
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("r0_pend_hit", RS_HIT, 1);
    check("r0_pend_fwd", RS_FWD, 123);
    cycle();
    check("r0_wrt", WRT, 1);
    check("r0_rd", Rd, 0);
    check("r0_data", DataIn, 123);
    check("r0_out_fwd", RT_FWD, 123);
    cycle();

    // random traffic: first half honours STALL, second half ignores it
    for (int i = 0; i < 400; i++) begin
      logic mv, av;
      mv = 1'($urandom_range(0, 1));
      av = 1'($urandom_range(0, 1));
      if (i < 200 && STALL) begin
        mv = 1'b0;
        av = 1'b0;
      end
      drive(mv, AW'($urandom_range(0, 7)), $urandom, av, AW'($urandom_range(0, 7)), $urandom);
      Rs = AW'($urandom_range(0, 7));
      Rt = AW'($urandom_range(0, 7));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 3) cycle();
    check("drain_empty", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
